// File: rtl/feature_frame_packer.sv
// Collects NFEAT float feature words into one parallel frame and hands it to the RNN core over valid/ready.
// Define FEATURE_PACKER_DBUF_EN to keep filling the capture buffer while a completed frame is still held.
module feature_frame_packer #(
    parameter int FLOAT = 32,
    parameter int NFEAT = 42,
    parameter int CNTW  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FLOAT-1:0]       in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [NFEAT*FLOAT-1:0] feature,
    output logic                   frame_valid,
    input  logic                   frame_ready,
    output logic                   frame_err,
    output logic [CNTW-1:0]        frame_cnt
);
    localparam int IDXW = $clog2(NFEAT);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NFEAT - 1);

    typedef enum logic {FILL, FULL} state_t;
    state_t state, state_next;

    logic [IDXW-1:0]        idx;
    logic [FLOAT-1:0]       cap [NFEAT];
    logic                   cap_full;
    logic                   word_acc;
    logic                   xfer;
    logic                   at_end;
    logic                   done;
    logic                   bad;
    logic                   load_out;
    logic                   use_live;
    logic [NFEAT*FLOAT-1:0] next_frame;

    assign word_acc = in_valid && in_ready;
    assign xfer     = frame_valid && frame_ready;
    assign at_end   = (idx == LAST_IDX);
    assign done     = word_acc && in_last && at_end;
    // A frame is malformed when in_last and the final slot disagree.
    assign bad      = word_acc && (in_last != at_end);

`ifdef FEATURE_PACKER_DBUF_EN
    // Completed capture goes straight out if the output is free (or freed now); otherwise it waits for the transfer.
    assign load_out = (done && (state == FILL || xfer)) || (cap_full && xfer);
    assign use_live = done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_full <= 1'b0;
        end else if (xfer) begin
            cap_full <= 1'b0;
        end else if (done && state == FULL) begin
            cap_full <= 1'b1;
        end
    end
`else
    assign load_out = done;
    assign use_live = 1'b1;
    assign cap_full = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL: if (load_out) state_next = FULL;
            FULL: if (xfer && !load_out) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_comb begin
        in_ready    = 1'b0;
        frame_valid = 1'b0;
        case (state)
            FILL: in_ready = !rst;
            FULL: begin
                frame_valid = 1'b1;
`ifdef FEATURE_PACKER_DBUF_EN
                in_ready    = !rst && !cap_full;
`endif
            end
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (word_acc) begin
            idx <= (at_end || in_last) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (word_acc) begin
            cap[idx] <= in_data;
        end
    end

    // The final word is taken from the bus when the frame completes this cycle.
    always_comb begin
        next_frame = '0;
        for (int i = 0; i < NFEAT - 1; i++) begin
            next_frame[i*FLOAT +: FLOAT] = cap[i];
        end
        next_frame[(NFEAT-1)*FLOAT +: FLOAT] = use_live ? in_data : cap[NFEAT-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            feature   <= '0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            frame_err <= bad;
            if (load_out) begin
                feature <= next_frame;
            end
            if (xfer) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_feature_frame_packer.sv
// Directed self-checking bench for feature_frame_packer; exercises the single-buffer build, or
// the ping-pong build when FEATURE_PACKER_DBUF_EN is defined.
module tb_feature_frame_packer;
    localparam int FLOAT = 32;
    localparam int NFEAT = 42;
    localparam int CNTW  = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [FLOAT-1:0]       in_data;
    logic                   in_valid;
    logic                   in_last;
    logic                   in_ready;
    logic [NFEAT*FLOAT-1:0] feature;
    logic                   frame_valid;
    logic                   frame_ready;
    logic                   frame_err;
    logic [CNTW-1:0]        frame_cnt;

    int checks = 0;
    int passed = 0;

    feature_frame_packer #(.FLOAT(FLOAT), .NFEAT(NFEAT), .CNTW(CNTW)) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_last(in_last),
        .in_ready(in_ready),
        .feature(feature),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .frame_err(frame_err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] wordAt(input int i);
        return feature[i*FLOAT +: FLOAT];
    endfunction

    // One word presented for one clock edge; outputs are then observed 1ns after that edge.
    task automatic applyStimulus(input logic [31:0] data, input logic last);
        in_data  = data;
        in_last  = last;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic sendFrame(input logic [31:0] base, input int n, input int last_pos);
        for (int i = 0; i < n; i++) begin
            applyStimulus(base + 32'(i), i == last_pos);
        end
    endtask

    task automatic pulseReady();
        frame_ready = 1'b1;
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        in_data     = '0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        frame_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_valid", frame_valid, 0);
        checkOutput("rst_err", frame_err, 0);
        checkOutput("rst_cnt", frame_cnt, 0);
        checkOutput("rst_feature_w0", wordAt(0), 0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", in_ready, 1);

`ifndef FEATURE_PACKER_DBUF_EN
        // Clean frame held while the core is not ready
        sendFrame(32'h3F80_0000, 41, -1);
        checkOutput("t1_not_valid_early", frame_valid, 0);
        applyStimulus(32'h3F80_0029, 1'b1);
        checkOutput("t1_valid", frame_valid, 1);
        checkOutput("t1_w0", wordAt(0), 32'h3F80_0000);
        checkOutput("t1_w17", wordAt(17), 32'h3F80_0011);
        checkOutput("t1_w41", wordAt(41), 32'h3F80_0029);
        checkOutput("t1_in_ready", in_ready, 0);
        checkOutput("t1_cnt", frame_cnt, 0);
        applyStimulus(32'hDEAD_BEEF, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t1_hold_valid", frame_valid, 1);
        checkOutput("t1_hold_w41", wordAt(41), 32'h3F80_0029);
        checkOutput("t1_hold_err", frame_err, 0);

        pulseReady();
        checkOutput("t2_valid", frame_valid, 0);
        checkOutput("t2_in_ready", in_ready, 1);
        checkOutput("t2_cnt", frame_cnt, 1);
        checkOutput("t2_w0_kept", wordAt(0), 32'h3F80_0000);

        // Early in_last
        sendFrame(32'h4000_0000, 10, 9);
        checkOutput("t3_err", frame_err, 1);
        checkOutput("t3_valid", frame_valid, 0);
        checkOutput("t3_w0_kept", wordAt(0), 32'h3F80_0000);
        @(posedge clk);
        #1;
        checkOutput("t3_err_pulse", frame_err, 0);
        sendFrame(32'h4100_0000, 42, 41);
        checkOutput("t3_valid_next", frame_valid, 1);
        checkOutput("t3_w0_next", wordAt(0), 32'h4100_0000);
        checkOutput("t3_w41_next", wordAt(41), 32'h4100_0029);
        checkOutput("t3_err_next", frame_err, 0);
        pulseReady();
        checkOutput("t3_cnt", frame_cnt, 2);

        // Missing in_last on the final slot
        sendFrame(32'h4200_0000, 42, -1);
        checkOutput("t4_err", frame_err, 1);
        checkOutput("t4_valid", frame_valid, 0);
        sendFrame(32'h4300_0000, 42, 41);
        checkOutput("t4_valid_next", frame_valid, 1);
        checkOutput("t4_w0_next", wordAt(0), 32'h4300_0000);
        checkOutput("t4_w41_next", wordAt(41), 32'h4300_0029);
        pulseReady();
        checkOutput("t4_cnt", frame_cnt, 3);

        // Reset in the middle of a frame
        sendFrame(32'h4400_0000, 20, -1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_cnt", frame_cnt, 0);
        checkOutput("t5_rst_w0", wordAt(0), 0);
        checkOutput("t5_rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sendFrame(32'h4500_0000, 42, 41);
        checkOutput("t5_valid", frame_valid, 1);
        checkOutput("t5_w0", wordAt(0), 32'h4500_0000);
        checkOutput("t5_w41", wordAt(41), 32'h4500_0029);
        checkOutput("t5_cnt_before", frame_cnt, 0);
        pulseReady();
        checkOutput("t5_cnt_after", frame_cnt, 1);
`else
        // Back-to-back frames with the core always ready
        frame_ready = 1'b1;
        for (int w = 0; w < 3 * NFEAT; w++) begin
            logic [31:0] base;
            base = 32'h5000_0000 + (32'(w / NFEAT) << 16);
            checkOutput("db_in_ready", in_ready, 1);
            applyStimulus(base + 32'(w % NFEAT), (w % NFEAT) == NFEAT - 1);
            if ((w % NFEAT) == NFEAT - 1) begin
                checkOutput("db_valid", frame_valid, 1);
                checkOutput("db_w0", wordAt(0), base);
                checkOutput("db_w41", wordAt(41), base + 32'd41);
            end else begin
                checkOutput("db_valid_low", frame_valid, 0);
            end
        end
        @(posedge clk);
        #1;
        checkOutput("db_cnt", frame_cnt, 3);
        checkOutput("db_valid_end", frame_valid, 0);

        // Output held: capture fills, then input stalls until the transfer swaps the frames
        frame_ready = 1'b0;
        sendFrame(32'h6000_0000, 42, 41);
        sendFrame(32'h6100_0000, 42, 41);
        checkOutput("db_stall_ready", in_ready, 0);
        checkOutput("db_stall_w0", wordAt(0), 32'h6000_0000);
        pulseReady();
        checkOutput("db_swap_valid", frame_valid, 1);
        checkOutput("db_swap_w0", wordAt(0), 32'h6100_0000);
        checkOutput("db_swap_w41", wordAt(41), 32'h6100_0029);
        checkOutput("db_swap_ready", in_ready, 1);
        checkOutput("db_swap_cnt", frame_cnt, 4);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/feature_frame_packer.md
Name: feature_frame_packer

Overview:
- Producer side of the RNN feature interface: accepts one 32-bit float feature word per handshake and assembles a full 42-word frame.
- Presents the frame on a flat parallel bus with a valid/ready frame handshake to the RNN inference core.
- Checks frame framing via an end-of-frame marker, drops malformed frames, and counts delivered frames.

Parameters:
- FLOAT, 32, bit width of one feature word
- NFEAT, 42, feature words per frame
- CNTW, 16, width of delivered-frame counter

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- in_data  input  FLOAT  feature word
- in_valid  input  1  in_data valid
- in_last  input  1  marks final word of frame; qualified by in_valid
- in_ready  output  1  packer can accept a word
- feature  output  NFEAT*FLOAT  assembled frame; word i at bits [i*FLOAT +: FLOAT]
- frame_valid  output  1  feature holds a complete frame
- frame_ready  input  1  RNN consumes frame
- frame_err  output  1  one-cycle pulse: framing error, frame dropped
- frame_cnt  output  CNTW  frames delivered (wrapping)

Behaviour:
- Word accept = in_valid && in_ready. Frame transfer = frame_valid && frame_ready. Both are sampled on the rising clk edge.
- Reset (async assert, sync-safe deassert in system): idx=0, state=FILL, in_ready=0 during reset then 1 first cycle after, feature=0, frame_valid=0, frame_err=0, frame_cnt=0.
- idx counts 0..NFEAT-1. An accepted word is written to capture slot idx, and idx increments.
- States:
  - FILL: in_ready=1, frame_valid=0.
    - Accept at idx=NFEAT-1 with in_last=1: go to FULL, frame_valid=1 next cycle (latency 1 cycle after the last word), idx returns to 0.
    - Accept with in_last=1 at idx<NFEAT-1: frame_err=1 next cycle, idx=0, partial data discarded, stay in FILL.
    - Accept at idx=NFEAT-1 with in_last=0: frame_err=1, idx=0, frame discarded, stay in FILL. The next word starts a new frame.
  - FULL: in_ready=0, frame_valid=1, feature held stable (no bit may change while frame_valid=1).
    - Transfer: frame_cnt+1 (wraps 2^CNTW-1 -> 0), frame_valid=0 and in_ready=1 next cycle, go to FILL.
- frame_valid, once asserted, must not drop without a transfer (except reset).
- feature retains the last delivered frame after transfer until overwritten by the next completed frame. Capture slots are internal and are not visible on feature until the frame completes.
- frame_err never coincides with frame_valid rising in single-buffer mode. It is a pulse, not sticky.
- in_data/in_last are ignored when in_valid=0 or in_ready=0.
- Reset mid-frame or mid-hold: all partial and held data discarded, frame_cnt cleared.

Optional Feature:
- Macro FEATURE_PACKER_DBUF_EN.
- Defined: ping-pong operation, with capture buffer and output register separate.
  - in_ready stays 1 in FULL while the capture buffer fills.
  - When the capture buffer completes and the output is free, or is freed in the same cycle by a transfer, the capture buffer is copied into feature and frame_valid=1 next cycle.
  - If the capture buffer is complete and the output is still held: in_ready=0 until transfer. The copy happens on the transfer cycle, so frame_valid stays 1 continuously with new data next cycle.
  - Sustained throughput: 42 words/42 cycles with frame_ready tied 1.
- Undefined: single-buffer behaviour above. No input is accepted while FULL.

Test Plan:
- Stream words 0x3F800000+i for i=0..41, in_last on i=41, frame_ready=0 -> frame_valid=1 one cycle after word 41; feature word 0=0x3F800000, word 41=0x3F800029; in_ready=0; frame_cnt=0.
- Continue the previous case: pulse frame_ready for 1 cycle -> frame_valid=0 and in_ready=1 next cycle, frame_cnt=1, feature unchanged.
- Send 10 words with in_last on word 9 -> frame_err pulses 1 cycle, no frame_valid; a following correct 42-word frame delivers with word 0 = first word after the error.
- Send 42 words with in_last=0 throughout -> frame_err pulse after word 41, frame_valid stays 0, idx restarts.
- Assert rst mid-frame at word 20, then send a full frame -> after reset, outputs are 0 and frame_cnt=0; the new frame's word 0 is the first post-reset word.
- FEATURE_PACKER_DBUF_EN, frame_ready=1 constant, 3 back-to-back frames, in_valid=1 -> in_ready never drops, frame_cnt=3, and each frame_valid pulse carries the correct data.
